// File: rtl/msrv32_pkg.sv
// Shared definitions for the msrv32 data-bus controller: FSM state
// encoding, access-size codes and small address helpers.
package msrv32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_RESP = 2'b11
  } dbus_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Natural alignment of an address for the given access size (size 1x = word).
  function automatic logic [31:0] dbus_align_addr(input logic [31:0] addr,
                                                  input logic [1:0]  size);
    logic [31:0] a;
    a = addr;
    if (size[1])
      a[1:0] = 2'b00;
    else if (size == SIZE_HALF)
      a[0] = 1'b0;
    return a;
  endfunction

  // True when the offset is not naturally aligned for the access size.
  function automatic logic dbus_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
    logic m;
    if (size[1])
      m = (off != 2'b00);
    else if (size == SIZE_HALF)
      m = off[0];
    else
      m = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/msrv32_dbus_lane_gen.sv
// Byte-lane strobe and store-data replication for the data bus.
// Loads produce an all-zero strobe; store data is replicated across lanes
// so the memory can pick the addressed lane without a shifter.
module msrv32_dbus_lane_gen
  import msrv32_pkg::*;
(
  input  logic        write_in,
  input  logic [1:0]  size_in,
  input  logic [1:0]  offset_in,
  input  logic [31:0] wdata_in,
  output logic [3:0]  mask_out,
  output logic [31:0] data_out
);

  // Strobe from size/offset, data replicated per access width.
  always_comb begin
    mask_out = '0;
    data_out = wdata_in;
    if (size_in[1]) begin
      mask_out = '1;
      data_out = wdata_in;
    end else if (size_in == SIZE_HALF) begin
      mask_out = offset_in[1] ? 4'b1100 : 4'b0011;
      data_out = {2{wdata_in[15:0]}};
    end else begin
      mask_out = 4'b0001 << offset_in;
      data_out = {4{wdata_in[7:0]}};
    end
    if (!write_in)
      mask_out = '0;
  end

endmodule

// File: rtl/msrv32_dbus_ctrl.sv
// Data-bus controller between MEM stage and an AHB-Lite style data port.
// One transfer outstanding; all bus and response outputs are registered.
// Optional feature macro: MSRV32_DBUS_MISALIGN_TRAP_EN (misaligned half/word
// accesses complete as a trap instead of being force-aligned on the bus).
module msrv32_dbus_ctrl
  import msrv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_write_in,
  input  logic [31:0] req_addr_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  input  logic [31:0] req_wdata_in,
  output logic [31:0] ms_riscv32_mp_dmaddr_out,
  output logic        ms_riscv32_mp_dmtrans_out,
  output logic        ms_riscv32_mp_dmwr_req_out,
  output logic [3:0]  ms_riscv32_mp_dmwr_mask_out,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_hready_in,
  input  logic        ms_riscv32_mp_hresp_in,
  output logic        rsp_valid_out,
  output logic        ahb_resp_out,
  output logic [31:0] load_data_out,
  output logic [1:0]  iadder_out_1_to_0_out,
  output logic [1:0]  load_size_out,
  output logic        load_unsigned_out,
  output logic        bus_err_out
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
  ,
  output logic        misaligned_exc_out
`endif
);

  dbus_state_e state_q, state_d;
  logic        ready_q, ready_d;
  logic        trans_q, trans_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_q, rsp_d;
  logic        ahb_q, ahb_d;
  logic [31:0] ld_q, ld_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [1:0]  lat_off_q, lat_off_d;
  logic [1:0]  lat_size_q, lat_size_d;
  logic        lat_uns_q, lat_uns_d;
  logic [31:0] cnt_q, cnt_d;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic        done;
  logic        done_err;

  msrv32_dbus_lane_gen u_lane_gen (
    .write_in  (req_write_in),
    .size_in   (req_size_in),
    .offset_in (req_addr_in[1:0]),
    .wdata_in  (req_wdata_in),
    .mask_out  (lane_mask),
    .data_out  (lane_data)
  );

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    trans_d    = trans_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    rsp_d      = 1'b0;
    ahb_d      = 1'b1;
    ld_d       = ld_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    err_d      = err_q;
    lat_off_d  = lat_off_q;
    lat_size_d = lat_size_q;
    lat_uns_d  = lat_uns_q;
    cnt_d      = cnt_q;
    done       = 1'b0;
    done_err   = 1'b0;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
    mis_d      = mis_q;
`endif
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid_in && ready_q) begin
          ready_d    = 1'b0;
          lat_off_d  = req_addr_in[1:0];
          lat_size_d = req_size_in;
          lat_uns_d  = req_unsigned_in;
          wr_d       = req_write_in;
          addr_d     = dbus_align_addr(req_addr_in, req_size_in);
          mask_d     = lane_mask;
          wdata_d    = lane_data;
          cnt_d      = '0;
          state_d    = ST_ADDR;
          trans_d    = 1'b1;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
          // Trap completes directly from IDLE with no bus phase at all.
          if (dbus_misaligned(req_size_in, req_addr_in[1:0])) begin
            state_d = ST_RESP;
            trans_d = 1'b0;
            wr_d    = 1'b0;
            mask_d  = '0;
            rsp_d   = 1'b1;
            err_d   = 1'b0;
            mis_d   = 1'b1;
            off_d   = req_addr_in[1:0];
            size_d  = req_size_in;
            uns_d   = req_unsigned_in;
          end
`endif
        end
      end
      ST_ADDR: begin
        if (ms_riscv32_mp_hready_in) begin
          state_d = ST_DATA;
          trans_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (ms_riscv32_mp_hready_in) begin
          done     = 1'b1;
          done_err = ms_riscv32_mp_hresp_in;
        end else if ((TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES)) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        if (done) begin
          state_d = ST_RESP;
          rsp_d   = 1'b1;
          err_d   = done_err;
          ahb_d   = wr_q | done_err;
          if (!wr_q && !done_err)
            ld_d = ms_riscv32_mp_dmdata_in;
          off_d   = lat_off_q;
          size_d  = lat_size_q;
          uns_d   = lat_uns_q;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
          mis_d   = 1'b0;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; async active-low reset drops any transfer.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      trans_q    <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      rsp_q      <= 1'b0;
      ahb_q      <= 1'b1;
      ld_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      lat_off_q  <= '0;
      lat_size_q <= '0;
      lat_uns_q  <= 1'b0;
      cnt_q      <= '0;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      trans_q    <= trans_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      rsp_q      <= rsp_d;
      ahb_q      <= ahb_d;
      ld_q       <= ld_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      err_q      <= err_d;
      lat_off_q  <= lat_off_d;
      lat_size_q <= lat_size_d;
      lat_uns_q  <= lat_uns_d;
      cnt_q      <= cnt_d;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  assign req_ready_out               = ready_q;
  assign ms_riscv32_mp_dmaddr_out    = addr_q;
  assign ms_riscv32_mp_dmtrans_out   = trans_q;
  assign ms_riscv32_mp_dmwr_req_out  = wr_q;
  assign ms_riscv32_mp_dmwr_mask_out = mask_q;
  assign ms_riscv32_mp_dmdata_out    = wdata_q;
  assign rsp_valid_out               = rsp_q;
  assign ahb_resp_out                = ahb_q;
  assign load_data_out               = ld_q;
  assign iadder_out_1_to_0_out       = off_q;
  assign load_size_out               = size_q;
  assign load_unsigned_out           = uns_q;
  assign bus_err_out                 = err_q;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
  assign misaligned_exc_out          = mis_q;
`endif

endmodule

// File: tb/tb_msrv32_dbus_ctrl.sv
// Self-checking bench for msrv32_dbus_ctrl: a transaction-level model
// expands each request into the expected per-cycle outputs, and one
// compare process checks the DUT against them every cycle.
module tb_msrv32_dbus_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_uns = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, rdata = '0;
  logic [1:0]  req_size = '0;
  logic        hready = 1'b1, hresp = 1'b0;

  logic        req_ready, dmtrans, dmwr, rsp_valid, ahb_resp, load_uns, bus_err;
  logic [31:0] dmaddr, dmdata, load_data;
  logic [3:0]  dmmask;
  logic [1:0]  load_off, load_size;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
  logic        mis_exc;
`endif

  always #5 clk = ~clk;

  msrv32_dbus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .ms_riscv32_mp_clk_in        (clk),
    .ms_riscv32_mp_rst_in        (rst_n),
    .req_valid_in                (req_valid),
    .req_ready_out               (req_ready),
    .req_write_in                (req_write),
    .req_addr_in                 (req_addr),
    .req_size_in                 (req_size),
    .req_unsigned_in             (req_uns),
    .req_wdata_in                (req_wdata),
    .ms_riscv32_mp_dmaddr_out    (dmaddr),
    .ms_riscv32_mp_dmtrans_out   (dmtrans),
    .ms_riscv32_mp_dmwr_req_out  (dmwr),
    .ms_riscv32_mp_dmwr_mask_out (dmmask),
    .ms_riscv32_mp_dmdata_out    (dmdata),
    .ms_riscv32_mp_dmdata_in     (rdata),
    .ms_riscv32_mp_hready_in     (hready),
    .ms_riscv32_mp_hresp_in      (hresp),
    .rsp_valid_out               (rsp_valid),
    .ahb_resp_out                (ahb_resp),
    .load_data_out               (load_data),
    .iadder_out_1_to_0_out       (load_off),
    .load_size_out               (load_size),
    .load_unsigned_out           (load_uns),
    .bus_err_out                 (bus_err)
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
    ,
    .misaligned_exc_out          (mis_exc)
`endif
  );

  typedef struct {
    bit          ready, trans, wr, chk_bus, chk_data, rsp, ahb, uns, err, mis;
    logic [31:0] addr, data, ld;
    logic [3:0]  mask;
    logic [1:0]  off, size;
  } exp_t;

  exp_t q[$];
  exp_t ce;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model of the held response fields.
  logic [31:0] m_ld = '0;
  logic [1:0]  m_off = '0, m_size = '0;
  bit          m_uns = 0, m_err = 0, m_mis = 0;

  // Observations used by the literal checks.
  int          acc_cyc = 0, last_rsp_cyc = 0, rsp_cnt = 0;
  bit          last_rsp_ahb = 0, trans_seen = 0;
  logic [3:0]  last_mask = '0;
  logic [31:0] last_addr = '0, last_data = '0;
  bit          last_wr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Single compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid) begin
        last_rsp_cyc = cyc;
        last_rsp_ahb = ahb_resp;
        rsp_cnt++;
      end
      if (dmtrans) begin
        trans_seen = 1;
        last_mask  = dmmask;
        last_addr  = dmaddr;
        last_wr    = dmwr;
      end
      if (!req_ready && !dmtrans && !rsp_valid) last_data = dmdata;
    end
    if (q.size() > 0) begin
      ce = q.pop_front();
      chk("ready", {31'd0, req_ready}, {31'd0, ce.ready});
      chk("dmtrans", {31'd0, dmtrans}, {31'd0, ce.trans});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, ce.rsp});
      chk("ahb_resp", {31'd0, ahb_resp}, {31'd0, ce.ahb});
      chk("load_data", load_data, ce.ld);
      chk("offset", {30'd0, load_off}, {30'd0, ce.off});
      chk("size", {30'd0, load_size}, {30'd0, ce.size});
      chk("unsigned", {31'd0, load_uns}, {31'd0, ce.uns});
      chk("bus_err", {31'd0, bus_err}, {31'd0, ce.err});
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
      chk("mis_exc", {31'd0, mis_exc}, {31'd0, ce.mis});
`endif
      if (ce.chk_bus) begin
        chk("dmaddr", dmaddr, ce.addr);
        chk("dmwr", {31'd0, dmwr}, {31'd0, ce.wr});
        chk("mask", {28'd0, dmmask}, {28'd0, ce.mask});
      end
      if (ce.chk_data) chk("dmdata", dmdata, ce.data);
    end
  end

  function automatic exp_t base();
    exp_t e;
    e = '{default: '0};
    e.ahb  = 1;
    e.ld   = m_ld;
    e.off  = m_off;
    e.size = m_size;
    e.uns  = m_uns;
    e.err  = m_err;
    e.mis  = m_mis;
    return e;
  endfunction

  function automatic logic [3:0] exp_mask(bit wr, logic [1:0] size, logic [31:0] a);
    int unsigned o;
    o = a % 4;
    if (!wr) return 4'd0;
    if (size >= 2) return 4'd15;
    if (size == 1) return 4'((3 << (2 * (o / 2))));
    return 4'((1 << o));
  endfunction

  function automatic logic [31:0] exp_data(logic [1:0] size, logic [31:0] w);
    if (size >= 2) return w;
    if (size == 1) return (w % 65536) * 32'h0001_0001;
    return (w % 256) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] exp_addr(logic [1:0] size, logic [31:0] a);
    if (size >= 2) return a - (a % 4);
    if (size == 1) return a - (a % 2);
    return a;
  endfunction

  function automatic bit is_trap(logic [1:0] size, logic [31:0] a);
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
    if (size >= 2) return (a % 4) != 0;
    if (size == 1) return (a % 2) != 0;
    return 0;
`else
    return (size == 2'b11) && (a == 32'hFFFF_FFFF) && (size != 2'b11);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle();
    exp_t e;
    e = base();
    e.ready = 1;
    q.push_back(e);
  endtask

  task automatic idle_cycle();
    req_valid = 0;
    hready = 1'($urandom);
    hresp = 1'($urandom);
    push_idle();
    step();
  endtask

  // One full transaction; aw/dw = hready-low cycles in ADDR/DATA.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wd, input int aw, input int dw,
                         input bit hr, input logic [31:0] rd);
    exp_t e;
    int   lows;
    bit   to;
    req_valid = 1; req_write = wr; req_addr = addr; req_size = size;
    req_uns = uns; req_wdata = wd;
    hready = 1'($urandom); hresp = 1'($urandom);
    trans_seen = 0;
    push_idle();
    acc_cyc = cyc;
    step();
    req_valid = 0;
    req_write = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_uns = 1'($urandom); req_wdata = $urandom;
    if (is_trap(size, addr)) begin
      m_off = addr[1:0]; m_size = size; m_uns = uns; m_err = 0; m_mis = 1;
      e = base();
      e.rsp = 1; e.ahb = 1;
      q.push_back(e);
      step();
    end else begin
      for (int i = 0; i <= aw; i++) begin
        hready = (i == aw); hresp = 1'($urandom);
        e = base();
        e.trans = 1; e.chk_bus = 1; e.wr = wr;
        e.addr = exp_addr(size, addr); e.mask = exp_mask(wr, size, addr);
        q.push_back(e);
        step();
      end
      lows = 0; to = 0;
      for (int i = 0; i <= dw; i++) begin
        e = base();
        e.chk_data = wr; e.data = exp_data(size, wd);
        q.push_back(e);
        if (i < dw) begin
          hready = 0; hresp = 1'($urandom); rdata = $urandom;
          step();
          lows++;
          if (TO != 0 && lows == TO) begin
            to = 1;
            break;
          end
        end else begin
          hready = 1; hresp = hr; rdata = rd;
          step();
        end
      end
      m_err = to || hr;
      if (!wr && !m_err) m_ld = rd;
      m_off = addr[1:0]; m_size = size; m_uns = uns; m_mis = 0;
      e = base();
      e.rsp = 1;
      e.ahb = wr || m_err;
      hready = 1'($urandom); hresp = 1'($urandom);
      q.push_back(e);
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_trans", {31'd0, dmtrans}, 32'd0);
    chk("rst_ahb", {31'd0, ahb_resp}, 32'd1);
    chk("rst_ldata", load_data, 32'd0);
    rst_n = 1;
    #3;
    chk("ready_before_edge", {31'd0, req_ready}, 32'd0);
    step();

    // Zero-wait word load.
    run_txn(0, 32'h100, 2'b10, 0, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);
    chk("lw_latency", last_rsp_cyc - acc_cyc, 32'd3);
    chk("lw_ahb_in_resp", {31'd0, last_rsp_ahb}, 32'd0);
    chk("lw_ldata", load_data, 32'hDEAD_BEEF);
    chk("lw_size", {30'd0, load_size}, 32'd2);
    chk("lw_ahb_after", {31'd0, ahb_resp}, 32'd1);

    // Byte store to lane 3.
    run_txn(1, 32'h203, 2'b00, 0, 32'h1234_56A5, 0, 0, 0, 32'h0);
    chk("sb_mask", {28'd0, last_mask}, 32'h8);
    chk("sb_wr", {31'd0, last_wr}, 32'd1);
    chk("sb_addr", last_addr, 32'h203);
    chk("sb_data", last_data, 32'hA5A5_A5A5);

    // Half load with 3 data wait states.
    run_txn(0, 32'h2, 2'b01, 1, 32'h0, 0, 3, 0, 32'h0BAD_F00D);
    chk("lh_latency", last_rsp_cyc - acc_cyc, 32'd6);
    chk("lh_off", {30'd0, load_off}, 32'd2);

    // Error response on a store.
    run_txn(1, 32'h300, 2'b10, 0, 32'hCAFE_0001, 1, 1, 1, 32'h0);
    chk("err_bus_err", {31'd0, bus_err}, 32'd1);
    chk("err_ahb", {31'd0, last_rsp_ahb}, 32'd1);

    // Timeout on a load (hready held low).
    run_txn(0, 32'h400, 2'b10, 0, 32'h0, 0, 10, 0, 32'h0);
    chk("to_latency", last_rsp_cyc - acc_cyc, 32'd6);
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_ahb", {31'd0, last_rsp_ahb}, 32'd1);
    chk("to_idle_ready", {31'd0, req_ready}, 32'd1);

    // Misaligned word load.
    run_txn(0, 32'h101, 2'b10, 0, 32'h0, 0, 0, 0, 32'h5555_AAAA);
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
    chk("mis_latency", last_rsp_cyc - acc_cyc, 32'd1);
    chk("mis_no_trans", {31'd0, trans_seen}, 32'd0);
    chk("mis_exc", {31'd0, mis_exc}, 32'd1);
`else
    chk("mis_bus_addr", last_addr, 32'h100);
    chk("mis_off", {30'd0, load_off}, 32'd1);
    chk("mis_ldata", load_data, 32'h5555_AAAA);
`endif

    // Reset in the DATA phase of a load.
    begin
      exp_t e;
      int   rc;
      req_valid = 1; req_write = 0; req_addr = 32'h40; req_size = 2'b10;
      push_idle();
      step();
      req_valid = 0; hready = 1;
      e = base(); e.trans = 1; e.chk_bus = 1; e.addr = 32'h40;
      q.push_back(e);
      step();
      hready = 0; rdata = 32'h1111_2222;
      rc = rsp_cnt;
      #2 rst_n = 0;
      #1;
      chk("rstd_ready", {31'd0, req_ready}, 32'd0);
      chk("rstd_ahb", {31'd0, ahb_resp}, 32'd1);
      chk("rstd_err", {31'd0, bus_err}, 32'd0);
      chk("rstd_addr", dmaddr, 32'd0);
      chk("rstd_ldata", load_data, 32'd0);
      chk("rstd_off", {30'd0, load_off}, 32'd0);
      m_ld = '0; m_off = '0; m_size = '0; m_uns = 0; m_err = 0; m_mis = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1; hready = 1;
      step();
      repeat (3) idle_cycle();
      chk("rstd_no_rsp", rsp_cnt - rc, 32'd0);
      run_txn(0, 32'h44, 2'b10, 0, 32'h0, 0, 0, 0, 32'h7777_8888);
      chk("rstd_fresh", load_data, 32'h7777_8888);
    end

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      run_txn(1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom,
              int'($urandom % 3), int'($urandom % 7), ($urandom % 5) == 0, $urandom);
      if ($urandom % 4 == 0) idle_cycle();
    end

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msrv32_dbus_ctrl.md
# msrv32_dbus_ctrl

Data-bus controller between the MEM stage and the AHB-Lite style data memory port, directly upstream of the load unit. It accepts one load/store request at a time from the pipeline, runs the address and data phases with wait-state and error handling, and builds byte-lane write masks and replicated store data. It returns captured read data together with the response, offset and size fields the load unit consumes.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of consecutive hready-low cycles in the data phase before the transfer is aborted. 0 disables the timeout.
- `ms_riscv32_mp_clk_in`  in  1  system clock, rising edge.
- `ms_riscv32_mp_rst_in`  in  1  reset, asynchronous, active-low.
- `req_valid_in`  in  1  request valid.
- `req_ready_out`  out  1  request accepted when valid && ready.
- `req_write_in`  in  1  1 = store, 0 = load.
- `req_addr_in`  in  32  effective address (iadder output).
- `req_size_in`  in  2  00 byte, 01 half, 1x word.
- `req_unsigned_in`  in  1  load zero-extend flag, passed through.
- `req_wdata_in`  in  32  raw rs2 data.
- `ms_riscv32_mp_dmaddr_out`  out  32  bus address.
- `ms_riscv32_mp_dmtrans_out`  out  1  address phase active.
- `ms_riscv32_mp_dmwr_req_out`  out  1  write transfer.
- `ms_riscv32_mp_dmwr_mask_out`  out  4  byte-lane strobes.
- `ms_riscv32_mp_dmdata_out`  out  32  store data, lane-replicated.
- `ms_riscv32_mp_dmdata_in`  in  32  read data.
- `ms_riscv32_mp_hready_in`  in  1  phase complete.
- `ms_riscv32_mp_hresp_in`  in  1  1 = error response.
- `rsp_valid_out`  out  1  one-cycle completion pulse.
- `ahb_resp_out`  out  1  0 = captured load data valid for the load unit.
- `load_data_out`  out  32  captured read word.
- `iadder_out_1_to_0_out`  out  2  latched address[1:0].
- `load_size_out`  out  2  latched size.
- `load_unsigned_out`  out  1  latched unsigned flag.
- `bus_err_out`  out  1  completion carried an error or timeout.
- `misaligned_exc_out`  out  1  completion was a misaligned trap; present only with the macro.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - `req_ready_out` = 1.
  - On accept, latch write, addr, size, unsigned and wdata, then go to ADDR.
- ADDR:
  - `dmtrans` = 1; address, write and mask are driven from the latches.
  - hready = 1: go to DATA.
  - hready = 0: hold all outputs.
- DATA:
  - `dmtrans` = 0; store data is driven.
  - hready = 1 && hresp = 0: capture read data (loads only), go to RESP.
  - hready = 1 && hresp = 1: go to RESP with the error set.
  - Timeout: the wait counter increments on each hready-low cycle. When it reaches `TIMEOUT_CYCLES` (nonzero), go to RESP with the error set.
- RESP:
  - `rsp_valid_out` = 1.
  - `ahb_resp_out` = 0 only for an error-free load.
  - Return to IDLE.
- Mask, word offset o = addr[1:0]:
  - byte: 0001 << o.
  - half: 0011 << {addr[1],0}.
  - word: 1111.
  - Loads: 0000.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Only one transfer is outstanding. No pipelining of a second address phase.

## Timing
- Zero wait states: accept at cycle 0, ADDR at cycle 1, DATA at cycle 2, RESP at cycle 3. Minimum request-to-response latency is 3 cycles; the next accept can occur at cycle 4.
- Each hready-low cycle in ADDR or DATA adds one cycle of latency.
- All bus and response outputs are registered. None combinationally depend on `req_*`.
- Response fields (`load_data_out`, offset, size, unsigned, `bus_err_out`) hold their values until the next RESP.
- `ahb_resp_out` returns to 1 on the cycle after RESP.
- Reset (asynchronous, any state):
  - FSM goes to IDLE and the wait counter clears.
  - `req_ready_out`, `dmtrans`, `dmwr_req`, `rsp_valid_out`, `bus_err_out` and `misaligned_exc_out` = 0.
  - Address, mask, `dmdata_out`, `load_data_out`, offset and size = 0; unsigned = 0.
  - `ahb_resp_out` = 1.
  - `req_ready_out` rises on the first clock edge after deassertion.
- An in-flight transfer is dropped on reset. No response is issued for it.

## Configuration
- `MSRV32_DBUS_MISALIGN_TRAP_EN` defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] ≠ 0, skips ADDR and DATA: IDLE goes straight to RESP.
  - In RESP: `misaligned_exc_out` = 1, `ahb_resp_out` = 1, no bus activity.
- Undefined:
  - The `misaligned_exc_out` port is absent.
  - The bus address is force-aligned (half: addr[0] cleared; word: addr[1:0] cleared) and the transfer proceeds normally.
  - `iadder_out_1_to_0_out` still reports the original bits.

## Structure
- Shared package `msrv32_pkg` holds:
  - the FSM state encoding;
  - size constants: SIZE_BYTE = 00, SIZE_HALF = 01, SIZE_WORD = 10.
- One sub-module, `msrv32_dbus_lane_gen`: combinational mask and store-data replication from size, offset and wdata.

## Test plan
- Load word, addr 0x100, zero wait, rdata 0xDEADBEEF → `rsp_valid_out` at cycle 3, `ahb_resp_out` = 0, `load_data_out` = 0xDEADBEEF, size 10.
- Store byte 0xA5, addr 0x203 → mask 1000, `dmdata_out` = 0xA5A5A5A5, `dmwr_req` = 1 in ADDR.
- Load half, addr 0x2, 3 hready-low cycles in DATA → response at cycle 6, offset 10, ready low throughout.
- hresp = 1 on a store; separately, hready held low with `TIMEOUT_CYCLES` = 4 → `bus_err_out` = 1, `ahb_resp_out` = 1, return to IDLE.
- Word load at 0x101 with the macro → trap at cycle 1 with no `dmtrans`. Without the macro → bus addr 0x100, offset 01.
- Reset asserted during DATA → all outputs reach reset values immediately; no `rsp_valid_out`; a fresh request afterwards completes normally.
